arm7tdmi_ice_watchunit: RTL and testbench

Parametrised successor to the two-comparator EmbeddedICE watch logic. Provides NUM_UNITS independent address/data comparator units. Each unit supports breakpoint/watchpoint type, read/write qualification, pass counts and chaining to the previous unit. Sits between the core's debug bus taps and the debug request path. Programmed through a clk-domain register port and drives a halt-request/acknowledge/restart state machine toward the core.

---
 rtl/arm7tdmi_ice_watchunit.sv | 224 ++++++++++++++++++++++
 tb/tb_arm7tdmi_ice_watchunit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_ice_watchunit.sv
// ============================================================================
//  arm7tdmi_ice_watchunit
//  NUM_UNITS address/data watch comparators with pass counts, chaining and a
//  halt-request/acknowledge/restart handshake toward the core.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module arm7tdmi_ice_watchunit #(
  parameter int NUM_UNITS = 4,
  parameter int CNT_W     = 8,
  parameter int RA_W      = $clog2(NUM_UNITS) + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_wr,
  input  logic [RA_W-1:0]      reg_addr,
  input  logic [31:0]          reg_wdata,
  output logic [31:0]          reg_rdata,
  input  logic                 bus_valid,
  input  logic                 bus_exec,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_data,
  input  logic                 bus_rw,
  input  logic                 dbgack,
  input  logic                 restart,
  output logic                 debug_req,
  output logic                 breakpoint,
  output logic                 watchpoint,
  output logic [NUM_UNITS-1:0] hit_vec,
  output logic                 halted
);

  localparam logic [RA_W-2:0] c_glb_status = (RA_W-1)'(0);
  localparam logic [RA_W-2:0] c_glb_gctrl  = (RA_W-1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t state_q;
  logic   debug_req_q, breakpoint_q, watchpoint_q, halted_q;

  logic [NUM_UNITS-1:0][31:0]      val_q,  val_d;
  logic [NUM_UNITS-1:0][31:0]      mask_q, mask_d;
  logic [NUM_UNITS-1:0][5:0]       ctrl_q, ctrl_d;
  logic [NUM_UNITS-1:0][CNT_W-1:0] cnt_q,  cnt_d;
  logic [NUM_UNITS-1:0]            armed_q, armed_d;
  logic [NUM_UNITS-1:0]            status_q, status_d;
  logic                            gen_q, gen_d;

  // Register address decode
  logic            w_is_glb;
  logic [RA_W-2:0] w_low;
  logic [1:0]      w_sel;
  logic [31:0]     w_unit_idx;

  assign w_is_glb   = reg_addr[RA_W-1];
  assign w_low      = reg_addr[RA_W-2:0];
  assign w_sel      = reg_addr[1:0];
  assign w_unit_idx = 32'(w_low >> 2);

  logic [NUM_UNITS-1:0] w_wr_val, w_wr_mask, w_wr_ctrl, w_wr_cnt;
  logic [NUM_UNITS-1:0] w_qmatch, w_fire, w_type;
  logic                 w_idle;

  assign w_idle = (state_q == ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic w_unit_wr, w_type_ok, w_rw_ok, w_addr_ok, w_data_ok, w_chain_ok;

      assign w_unit_wr     = reg_wr & ~w_is_glb & (w_unit_idx == gi);
      assign w_wr_val[gi]  = w_unit_wr & (w_sel == 2'd0);
      assign w_wr_mask[gi] = w_unit_wr & (w_sel == 2'd1);
      assign w_wr_ctrl[gi] = w_unit_wr & (w_sel == 2'd2);
      assign w_wr_cnt[gi]  = w_unit_wr & (w_sel == 2'd3);

      assign w_type[gi] = ctrl_q[gi][1];
      assign w_type_ok  = ctrl_q[gi][1] ? ~bus_exec : bus_exec;
      assign w_rw_ok    = (ctrl_q[gi][3:2] == 2'b01) ? bus_rw  :
                          (ctrl_q[gi][3:2] == 2'b10) ? ~bus_rw : 1'b1;
      assign w_addr_ok  = ((bus_addr ^ val_q[gi]) & mask_q[gi]) == 32'd0;
      // Data-compare watchpoints reuse the address VAL/MASK pair for the data
      assign w_data_ok  = ~(ctrl_q[gi][1] & ctrl_q[gi][5]) |
                          (((bus_data ^ val_q[gi]) & mask_q[gi]) == 32'd0);

      if (gi == 0) begin : g_first
        assign w_chain_ok = 1'b1;
      end else begin : g_chained
        assign w_chain_ok = ~ctrl_q[gi][4] | armed_q[gi];
      end

      assign w_qmatch[gi] = w_idle & gen_q & ctrl_q[gi][0] & bus_valid &
                            w_type_ok & w_rw_ok & w_addr_ok & w_data_ok &
                            w_chain_ok;
      assign w_fire[gi]   = w_qmatch[gi] & (cnt_q[gi] == '0);
    end
  endgenerate

  logic w_wr_status, w_wr_gctrl, w_fire_bp, w_fire_wp;

  assign w_wr_status = reg_wr & w_is_glb & (w_low == c_glb_status);
  assign w_wr_gctrl  = reg_wr & w_is_glb & (w_low == c_glb_gctrl);
  assign w_fire_bp   = |(w_fire & ~w_type);
  assign w_fire_wp   = |(w_fire &  w_type);

  // Next-state for the programmable registers; writes override counting
  always_comb begin
    val_d  = val_q;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    gen_d  = w_wr_gctrl ? reg_wdata[0] : gen_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_qmatch[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - 1'b1;
      if (w_wr_val[i])  val_d[i]  = reg_wdata;
      if (w_wr_mask[i]) mask_d[i] = reg_wdata;
      if (w_wr_ctrl[i]) ctrl_d[i] = reg_wdata[5:0];
      if (w_wr_cnt[i])  cnt_d[i]  = reg_wdata[CNT_W-1:0];
    end
    armed_d  = (armed_q | (w_fire << 1)) & ~w_fire & ~w_wr_ctrl;
    status_d = (w_wr_status ? (status_q & ~reg_wdata[NUM_UNITS-1:0]) : status_q)
               | w_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q    <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
      armed_q  <= '0;
      status_q <= '0;
      gen_q    <= 1'b0;
    end else begin
      val_q    <= val_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      status_q <= status_d;
      gen_q    <= gen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      debug_req_q  <= 1'b0;
      breakpoint_q <= 1'b0;
      watchpoint_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|w_fire) begin
            state_q      <= ST_REQ;
            debug_req_q  <= 1'b1;
            breakpoint_q <= w_fire_bp;
            watchpoint_q <= w_fire_wp;
          end
        end
        ST_REQ: begin
          if (dbgack) begin
            state_q     <= ST_HALTED;
            debug_req_q <= 1'b0;
            halted_q    <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (restart) begin
            state_q  <= ST_RESUME;
            halted_q <= 1'b0;
          end
        end
        ST_RESUME: begin
          if (!dbgack) begin
            state_q      <= ST_IDLE;
            breakpoint_q <= 1'b0;
            watchpoint_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          debug_req_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = 32'd0;
    if (w_is_glb) begin
      if (w_low == c_glb_status)     reg_rdata[NUM_UNITS-1:0] = status_q;
      else if (w_low == c_glb_gctrl) reg_rdata[0] = gen_q;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (w_unit_idx == i) begin
          case (w_sel)
            2'd0:    reg_rdata = val_q[i];
            2'd1:    reg_rdata = mask_q[i];
            2'd2:    reg_rdata[5:0] = ctrl_q[i];
            default: reg_rdata[CNT_W-1:0] = cnt_q[i];
          endcase
        end
      end
    end
  end

  assign debug_req  = debug_req_q;
  assign breakpoint = breakpoint_q;
  assign watchpoint = watchpoint_q;
  assign halted     = halted_q;
  assign hit_vec    = status_q;

endmodule

`default_nettype wire

// File: tb/tb_arm7tdmi_ice_watchunit.sv
// ============================================================================
//  tb_arm7tdmi_ice_watchunit
//  Directed bench with a per-cycle reference model of the watch unit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arm7tdmi_ice_watchunit;

  localparam int NU = 4;
  localparam int RAW = 5;
  localparam logic [4:0] A_STATUS = 5'd16;
  localparam logic [4:0] A_GCTRL  = 5'd17;

  logic          clk = 1'b0;
  logic          rst_n, reg_wr, bus_valid, bus_exec, bus_rw, dbgack, restart;
  logic [RAW-1:0] reg_addr;
  logic [31:0]   reg_wdata, reg_rdata, bus_addr, bus_data;
  logic          debug_req, breakpoint, watchpoint, halted;
  logic [NU-1:0] hit_vec;

  arm7tdmi_ice_watchunit #(.NUM_UNITS(NU), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .bus_valid(bus_valid),
    .bus_exec(bus_exec), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rw(bus_rw), .dbgack(dbgack), .restart(restart),
    .debug_req(debug_req), .breakpoint(breakpoint), .watchpoint(watchpoint),
    .hit_vec(hit_vec), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0] m_val [NU];
  bit [31:0] m_mask[NU];
  bit [5:0]  m_ctrl[NU];
  int        m_cnt [NU];
  bit        m_armed[NU];
  bit [3:0]  m_status;
  bit        m_gen;
  int        m_st;      // 0 idle, 1 request, 2 halted, 3 resume
  bit        m_bp, m_wp;
  bit        model_ok = 1'b0;

  function automatic bit unit_hits(int i);
    bit [5:0] c = m_ctrl[i];
    if (!m_gen || !c[0] || !bus_valid) return 1'b0;
    if (c[1] == bus_exec) return 1'b0;
    if (c[3:2] == 2'b01 && !bus_rw) return 1'b0;
    if (c[3:2] == 2'b10 &&  bus_rw) return 1'b0;
    if ((bus_addr & m_mask[i]) != (m_val[i] & m_mask[i])) return 1'b0;
    if (c[1] && c[5] && ((bus_data & m_mask[i]) != (m_val[i] & m_mask[i]))) return 1'b0;
    if (i > 0 && c[4] && !m_armed[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_rd(logic [4:0] a);
    int u = int'(a[3:2]);
    if (a[4]) begin
      if (a[3:0] == 4'd0) return {28'd0, m_status};
      if (a[3:0] == 4'd1) return {31'd0, m_gen};
      return 32'd0;
    end
    case (a[1:0])
      2'd0:    return m_val[u];
      2'd1:    return m_mask[u];
      2'd2:    return {26'd0, m_ctrl[u]};
      default: return 32'(m_cnt[u]);
    endcase
  endfunction

  task automatic model_step();
    bit [3:0] fired = '0;
    bit any_bp = 0, any_wp = 0;
    int u;
    if (!rst_n) begin
      for (int i = 0; i < NU; i++) begin
        m_val[i] = 0; m_mask[i] = 0; m_ctrl[i] = 0; m_cnt[i] = 0; m_armed[i] = 0;
      end
      m_status = 0; m_gen = 0; m_st = 0; m_bp = 0; m_wp = 0;
      model_ok = 1'b1;
      return;
    end
    if (m_st == 0) begin
      for (int i = 0; i < NU; i++) begin
        if (unit_hits(i)) begin
          if (m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
          else begin
            fired[i] = 1'b1;
            if (m_ctrl[i][1]) any_wp = 1; else any_bp = 1;
          end
        end
      end
    end
    for (int i = NU - 1; i >= 1; i--) begin
      if (fired[i-1]) m_armed[i] = 1'b1;
      if (fired[i])   m_armed[i] = 1'b0;
    end
    if (reg_wr && reg_addr == A_STATUS) m_status = m_status & ~reg_wdata[3:0];
    m_status = m_status | fired;
    if (reg_wr) begin
      if (!reg_addr[4]) begin
        u = int'(reg_addr[3:2]);
        case (reg_addr[1:0])
          2'd0: m_val[u]  = reg_wdata;
          2'd1: m_mask[u] = reg_wdata;
          2'd2: begin m_ctrl[u] = reg_wdata[5:0]; m_armed[u] = 1'b0; end
          default: m_cnt[u] = int'(reg_wdata[7:0]);
        endcase
      end else if (reg_addr == A_GCTRL) begin
        m_gen = reg_wdata[0];
      end
    end
    case (m_st)
      0: if (fired != 0) begin m_st = 1; m_bp = any_bp; m_wp = any_wp; end
      1: if (dbgack) m_st = 2;
      2: if (restart) m_st = 3;
      default: if (!dbgack) begin m_st = 0; m_bp = 0; m_wp = 0; end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("debug_req",  {31'd0, debug_req},  {31'd0, m_st == 1});
    check("halted",     {31'd0, halted},     {31'd0, m_st == 2});
    check("breakpoint", {31'd0, breakpoint}, {31'd0, m_bp});
    check("watchpoint", {31'd0, watchpoint}, {31'd0, m_wp});
    check("hit_vec",    {28'd0, hit_vec},    {28'd0, m_status});
    check("reg_rdata",  reg_rdata,           model_rd(reg_addr));
  endtask

  // One cycle: compare at the falling edge, then advance model and DUT
  task automatic tick();
    @(negedge clk);
    if (model_ok) compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr = 1; reg_addr = a; reg_wdata = d;
    tick();
    reg_wr = 0; reg_addr = 0; reg_wdata = 0;
  endtask

  task automatic acc(input logic ex, input logic [31:0] a, input logic [31:0] d, input logic rw);
    bus_valid = 1; bus_exec = ex; bus_addr = a; bus_data = d; bus_rw = rw;
    tick();
    bus_valid = 0; bus_exec = 0; bus_addr = 0; bus_data = 0; bus_rw = 0;
  endtask

  task automatic acc_wr(input logic [4:0] ra, input logic [31:0] rd, input logic [31:0] a);
    reg_wr = 1; reg_addr = ra; reg_wdata = rd;
    bus_valid = 1; bus_exec = 1; bus_addr = a; bus_data = 0; bus_rw = 1;
    tick();
    reg_wr = 0; reg_addr = 0; reg_wdata = 0;
    bus_valid = 0; bus_exec = 0; bus_addr = 0; bus_rw = 0;
  endtask

  task automatic release_core();
    dbgack = 1; tick();
    restart = 1; tick();
    restart = 0; dbgack = 0; tick();
  endtask

  task automatic outs_is(input string name, input logic [7:0] exp);
    check(name, {24'd0, debug_req, breakpoint, watchpoint, halted, hit_vec}, {24'd0, exp});
  endtask

  task automatic rd_is(input string name, input logic [4:0] a, input logic [31:0] exp);
    reg_addr = a; #1;
    check(name, reg_rdata, exp);
  endtask

  function automatic logic [4:0] ua(int u, int s);
    return 5'((u << 2) | s);
  endfunction

  initial begin
    rst_n = 0; reg_wr = 0; reg_addr = 0; reg_wdata = 0; bus_valid = 0;
    bus_exec = 0; bus_addr = 0; bus_data = 0; bus_rw = 0; dbgack = 0; restart = 0;
    tick(); tick();
    rst_n = 1;
    outs_is("reset_outs", 8'h00);
    rd_is("reset_status", A_STATUS, 32'd0);

    // Basic breakpoint and full handshake
    wr(ua(0,0), 32'h100); wr(ua(0,1), 32'hFFFF_FFFF); wr(ua(0,2), 32'h1); wr(A_GCTRL, 32'h1);
    acc(1, 32'h100, 0, 1);
    outs_is("bp_fire", 8'hC1);
    dbgack = 1; tick();
    outs_is("bp_halted", 8'h51);
    restart = 1; tick(); restart = 0;
    outs_is("bp_resume", 8'h41);
    dbgack = 0; tick();
    outs_is("bp_idle", 8'h01);
    wr(A_STATUS, 32'hF);

    // Write-only watchpoint
    wr(ua(1,0), 32'h2000); wr(ua(1,1), 32'hFFFF_FF00); wr(ua(1,2), 32'hB);
    acc(0, 32'h2010, 32'h0, 1);
    outs_is("wp_read_miss", 8'h00);
    acc(0, 32'h20FC, 32'h0, 0);
    outs_is("wp_write_hit", 8'hA2);
    release_core(); wr(A_STATUS, 32'hF);

    // Pass count on unit 0
    wr(ua(1,2), 32'h0); wr(ua(0,3), 32'd3);
    acc(1, 32'h100, 0, 1); outs_is("cnt_pass1", 8'h00); rd_is("cnt_2", ua(0,3), 32'd2);
    acc(1, 32'h100, 0, 1); outs_is("cnt_pass2", 8'h00); rd_is("cnt_1", ua(0,3), 32'd1);
    acc(1, 32'h100, 0, 1); outs_is("cnt_pass3", 8'h00); rd_is("cnt_0", ua(0,3), 32'd0);
    acc(1, 32'h100, 0, 1); outs_is("cnt_fire", 8'hC1);
    release_core(); wr(A_STATUS, 32'hF);

    // Chain unit1 behind unit0
    wr(ua(0,0), 32'h200);
    wr(ua(1,0), 32'h300); wr(ua(1,1), 32'hFFFF_FFFF); wr(ua(1,2), 32'h11);
    acc(1, 32'h300, 0, 1); outs_is("chain_unarmed", 8'h00);
    acc(1, 32'h200, 0, 1); outs_is("chain_u0", 8'hC1);
    release_core(); wr(A_STATUS, 32'hF);
    acc(1, 32'h300, 0, 1); outs_is("chain_u1", 8'hC2);
    release_core(); wr(A_STATUS, 32'hF);
    acc(1, 32'h300, 0, 1); outs_is("chain_disarmed", 8'h00);

    // Simultaneous fires and STATUS W1C
    wr(ua(1,2), 32'h0);
    wr(ua(0,0), 32'h400);
    wr(ua(2,0), 32'h400); wr(ua(2,1), 32'hFFFF_FFFF); wr(ua(2,2), 32'h1);
    acc(1, 32'h400, 0, 1); outs_is("simul_fire", 8'hC5);
    release_core();
    wr(A_STATUS, 32'h1); outs_is("w1c_bit0", 8'h04);
    acc_wr(A_STATUS, 32'h5, 32'h400); outs_is("w1c_vs_fire", 8'hC5);
    release_core(); wr(A_STATUS, 32'hF);

    // Data-compare watchpoint on unit 3
    wr(ua(2,2), 32'h0);
    wr(ua(3,0), 32'h5000); wr(ua(3,1), 32'hFFFF_F000); wr(ua(3,2), 32'h23);
    acc(0, 32'h5004, 32'h6000, 0); outs_is("dcmp_miss", 8'h00);
    acc(0, 32'h5004, 32'h5FFF, 0); outs_is("dcmp_hit", 8'hA8);
    release_core(); wr(A_STATUS, 32'hF);

    // Reset while halted
    acc(0, 32'h5008, 32'h5000, 1);
    dbgack = 1; tick();
    outs_is("pre_reset_halted", 8'h38);
    rst_n = 0; tick(); rst_n = 1; dbgack = 0;
    outs_is("post_reset_outs", 8'h00);
    rd_is("post_reset_val3", ua(3,0), 32'd0);
    rd_is("post_reset_ctrl3", ua(3,2), 32'd0);
    rd_is("post_reset_gctrl", A_GCTRL, 32'd0);
    wr(ua(0,0), 32'h100); wr(ua(0,1), 32'hFFFF_FFFF); wr(ua(0,2), 32'h1);
    acc(1, 32'h100, 0, 1); outs_is("gctrl_off", 8'h00);
    wr(A_GCTRL, 32'h1);
    acc_wr(ua(0,2), 32'h0, 32'h100); outs_is("prewrite_match", 8'hC1);
    release_core(); wr(A_STATUS, 32'hF);
    acc(1, 32'h100, 0, 1); outs_is("ctrl_cleared", 8'h00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
